// File: rtl/stereo_pkg.sv
// Shared constants and types for the stereo image loader: protocol bytes,
// loader FSM states and image geometry.
package stereo_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] SEL_LEFT  = 8'h00;
    localparam logic [7:0] SEL_RIGHT = 8'h01;

    localparam int IMG_W      = 320;
    localparam int IMG_H      = 240;
    localparam int BLOCK_SIZE = 6;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        WAIT_SEL,
        LOAD
    } loader_state;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver; byte_valid/frame_err pulse one cycle after the stop-bit centre.
// No backpressure: each byte is presented once and must be consumed that cycle.
module uart_rx_byte #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 3000000
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       uart_rxd,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CPB      = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT = CPB / 2;
    localparam int CW       = $clog2(CPB + 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state_q;
    logic          rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          valid_q, err_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (rxd_prev_q && !rxd_sync_q) state_q <= RX_START;
                end
                RX_START: begin
                    if (cnt_q == HALF_END) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // A line already back high at mid-start is a glitch, not a byte.
                        state_q   <= rxd_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q   <= '0;
                        shift_q <= {rxd_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) state_q <= RX_STOP;
                        else                   bit_idx_q <= bit_idx_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_END) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rxd_sync_q) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign frame_err  = err_q;

endmodule

// File: rtl/bram_uart_loader.sv
// Loads a framed UART image into the left/right BRAM; word write 1 cycle after its last byte, done 1 cycle later.
// No backpressure: a BRAM write always completes within the byte time.
module bram_uart_loader
    import stereo_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 3000000,
    parameter int WORD_BYTES = BLOCK_SIZE,
    parameter int DEPTH      = 12800
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     uart_rxd,
    output logic [$clog2(DEPTH)-1:0] addr_out,
    output logic [8*WORD_BYTES-1:0]  data_out,
    output logic                     left_we_out,
    output logic                     right_we_out,
    output logic                     load_done_out,
    output logic                     busy_out,
    output logic                     error_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = 8 * WORD_BYTES;
    localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);
    localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

    logic [7:0] rx_byte;
    logic       rx_vld, rx_err;

    uart_rx_byte #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .uart_rxd   (uart_rxd),
        .byte_out   (rx_byte),
        .byte_valid (rx_vld),
        .frame_err  (rx_err)
    );

    loader_state   state_q;
    logic          sel_right_q, last_q;
    logic [BW-1:0] byte_cnt_q;
    logic [AW-1:0] word_cnt_q, addr_q;
    logic [DW-1:0] word_q, data_q, word_d;
    logic          left_we_q, right_we_q, done_q, busy_q, err_q;

    // First byte of a word ends up in the MSBs after WORD_BYTES shifts.
    assign word_d = (word_q << 8) | DW'(rx_byte);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= WAIT_SYNC;
            sel_right_q <= 1'b0;
            last_q      <= 1'b0;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            word_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            left_we_q   <= 1'b0;
            right_we_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            left_we_q  <= 1'b0;
            right_we_q <= 1'b0;
            done_q     <= 1'b0;
            if (rx_err) begin
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
                last_q  <= 1'b0;
                state_q <= WAIT_SYNC;
            end else if (last_q) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                last_q  <= 1'b0;
                state_q <= WAIT_SYNC;
            end else if (rx_vld) begin
                case (state_q)
                    WAIT_SYNC: begin
                        if (rx_byte == SYNC_BYTE) begin
                            err_q   <= 1'b0;
                            state_q <= WAIT_SEL;
                        end
                    end
                    WAIT_SEL: begin
                        if (rx_byte == SEL_LEFT || rx_byte == SEL_RIGHT) begin
                            sel_right_q <= (rx_byte == SEL_RIGHT);
                            byte_cnt_q  <= '0;
                            word_cnt_q  <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= LOAD;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= WAIT_SYNC;
                        end
                    end
                    LOAD: begin
                        word_q <= word_d;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_q <= '0;
                            addr_q     <= word_cnt_q;
                            data_q     <= word_d;
                            left_we_q  <= !sel_right_q;
                            right_we_q <= sel_right_q;
                            if (word_cnt_q == LAST_WORD) last_q <= 1'b1;
                            else                         word_cnt_q <= word_cnt_q + 1'b1;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= WAIT_SYNC;
                endcase
            end
        end
    end

    assign addr_out      = addr_q;
    assign data_out      = data_q;
    assign left_we_out   = left_we_q;
    assign right_we_out  = right_we_q;
    assign load_done_out = done_q;
    assign busy_out      = busy_q;
    assign error_out     = err_q;

endmodule

// File: tb/tb_bram_uart_loader.sv
// Directed stimulus for bram_uart_loader with a write scoreboard (DEPTH=4, 33-cycle bit period).
module tb_bram_uart_loader;

    localparam int CPB = 33;

    typedef struct packed {
        logic        right;
        logic [1:0]  addr;
        logic [47:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rxd;
    logic [1:0]  addr_out;
    logic [47:0] data_out;
    logic        left_we_out, right_we_out, load_done_out, busy_out, error_out;

    int  n_assert = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    int  last_wr_cyc = 0;
    int  strobe_cnt  = 0;
    int  done_cnt    = 0;
    wr_t exp_q[$];
    wr_t e;

    bram_uart_loader #(
        .CLK_FREQ   (100000000),
        .BAUD_RATE  (3000000),
        .WORD_BYTES (6),
        .DEPTH      (4)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .uart_rxd      (uart_rxd),
        .addr_out      (addr_out),
        .data_out      (data_out),
        .left_we_out   (left_we_out),
        .right_we_out  (right_we_out),
        .load_done_out (load_done_out),
        .busy_out      (busy_out),
        .error_out     (error_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (left_we_out || right_we_out) begin
            strobe_cnt++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'({left_we_out, right_we_out}), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("we_left", 64'(left_we_out), 64'(!e.right));
                check("we_right", 64'(right_we_out), 64'(e.right));
                check("addr", 64'(addr_out), 64'(e.addr));
                check("data", 64'(data_out), 64'(e.data));
                check("busy_at_write", 64'(busy_out), 64'(1));
            end
        end
        if (load_done_out) begin
            done_cnt++;
            check("done_latency", 64'(cyc - last_wr_cyc), 64'(1));
            check("done_busy_low", 64'(busy_out), 64'(0));
            check("done_addr_hold", 64'(addr_out), 64'(3));
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        uart_rxd = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            wait_cyc(CPB);
        end
        uart_rxd = stop;
        wait_cyc(CPB);
        uart_rxd = 1'b1;
        if (!stop) wait_cyc(CPB);
    endtask

    task automatic glitch();
        uart_rxd = 1'b0;
        wait_cyc(10);
        uart_rxd = 1'b1;
        wait_cyc(2 * CPB);
    endtask

    // Sends sync, select and 24 pixels start + step*i; expects 4 writes and one done pulse.
    task automatic send_image(input logic right, input logic [7:0] start,
                              input logic [7:0] step, input int glitch_at);
        logic [47:0] w;
        logic [7:0]  b;
        wr_t         ex;
        int          done0;
        w = '0;
        done0 = done_cnt;
        send_byte(8'hA5);
        check("err_cleared_by_sync", 64'(error_out), 64'(0));
        send_byte(right ? 8'h01 : 8'h00);
        check("busy_after_sel", 64'(busy_out), 64'(1));
        for (int i = 0; i < 24; i++) begin
            b = start + 8'(int'(step) * i);
            if (i == glitch_at) glitch();
            w[8*(5 - (i % 6)) +: 8] = b;
            if (i % 6 == 5) begin
                ex.right = right;
                ex.addr  = 2'(i / 6);
                ex.data  = w;
                exp_q.push_back(ex);
            end
            send_byte(b);
        end
        wait_cyc(5);
        check("image_done_count", 64'(done_cnt), 64'(done0 + 1));
        check("image_busy_end", 64'(busy_out), 64'(0));
        check("image_err_end", 64'(error_out), 64'(0));
        check("image_writes_drained", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, 64'(addr_out), 64'(0));
        check({tag, "_data"}, 64'(data_out), 64'(0));
        check({tag, "_we"}, 64'({left_we_out, right_we_out}), 64'(0));
        check({tag, "_done"}, 64'(load_done_out), 64'(0));
        check({tag, "_busy"}, 64'(busy_out), 64'(0));
        check({tag, "_err"}, 64'(error_out), 64'(0));
    endtask

    initial begin
        int s0, d0;
        wr_t ex;
        rst_n    = 1'b0;
        uart_rxd = 1'b1;
        wait_cyc(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        wait_cyc(5);

        // Left image 01..18, then right image of FF.
        send_image(1'b0, 8'h01, 8'h01, -1);
        send_image(1'b1, 8'hFF, 8'h00, -1);

        // Junk before sync is ignored; a bad select flags an error.
        s0 = strobe_cnt;
        send_byte(8'h3C);
        wait_cyc(3);
        check("junk_err", 64'(error_out), 64'(0));
        check("junk_busy", 64'(busy_out), 64'(0));
        send_byte(8'hA5);
        send_byte(8'h07);
        wait_cyc(3);
        check("badsel_err", 64'(error_out), 64'(1));
        check("badsel_busy", 64'(busy_out), 64'(0));
        check("badsel_no_write", 64'(strobe_cnt), 64'(s0));
        send_image(1'b0, 8'h40, 8'h03, -1);

        // Framing error after one full word and two pixels of the next.
        s0 = strobe_cnt;
        d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        ex.right = 1'b0;
        ex.addr  = 2'd0;
        ex.data  = 48'h010203040506;
        exp_q.push_back(ex);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h55, 1'b0);
        wait_cyc(5);
        check("frame_err_flag", 64'(error_out), 64'(1));
        check("frame_err_busy", 64'(busy_out), 64'(0));
        check("frame_err_writes", 64'(strobe_cnt), 64'(s0 + 1));
        check("frame_err_no_done", 64'(done_cnt), 64'(d0));

        // Short low glitch while idle: nothing decoded, error stays sticky.
        s0 = strobe_cnt;
        glitch();
        wait_cyc(3 * CPB);
        check("glitch_err_sticky", 64'(error_out), 64'(1));
        check("glitch_busy", 64'(busy_out), 64'(0));
        check("glitch_no_write", 64'(strobe_cnt), 64'(s0));
        // Glitch in the middle of a load must not insert a pixel.
        send_image(1'b0, 8'h80, 8'h05, 3);

        // Asynchronous reset mid-word aborts the load.
        d0 = done_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        ex.right = 1'b0;
        ex.addr  = 2'd0;
        ex.data  = 48'h010203040506;
        exp_q.push_back(ex);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5 * CPB);
        check("reset_no_done", 64'(done_cnt), 64'(d0));
        check("reset_busy_low", 64'(busy_out), 64'(0));
        // A5 inside LOAD is pixel data; load restarts from address 0.
        send_image(1'b0, 8'hA5, 8'h00, -1);

        check("total_done", 64'(done_cnt), 64'(5));
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
